// File: rtl/pci_bridge_wb_pkg.sv
// Shared types and helpers for the PCI bridge WISHBONE slave responder.
// Holds the cycle/burst type encodings, the responder state set and burst address stepping.
package pci_bridge_wb_pkg;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_BURST
   } resp_state_e;

   // Wrapping bursts step only the word bits inside the wrap window; upper bits stay fixed.
   function automatic logic [31:0] next_burst_addr(input logic [31:0] addr, input logic [1:0] bte);
      logic [31:0] nxt;
      nxt = addr;
      case (bte)
         BTE_WRAP4:  nxt[3:2] = addr[3:2] + 2'd1;
         BTE_WRAP8:  nxt[4:2] = addr[4:2] + 3'd1;
         BTE_WRAP16: nxt[5:2] = addr[5:2] + 4'd1;
         default:    nxt      = addr + 32'd4;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pci_bridge_wb_slave_responder_bytemem.sv
// Single-port 32-bit word memory with per-byte write mask and combinational read.
// Contents are deliberately not reset.
module pci_bridge_wb_bytemem #(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    sel,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/pci_bridge_wb_slave_responder.sv
// WISHBONE slave target for the PCI bridge master port: wait states, retry injection,
// registered-feedback bursts with zero-wait beats, and saturating termination statistics.
module pci_bridge_wb_slave_responder
   import pci_bridge_wb_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ADR_O,
   input  logic [31:0]      MDAT_O,
   input  logic [3:0]       SEL_O,
   input  logic             CYC_O,
   input  logic             STB_O,
   input  logic             WE_O,
   input  logic [2:0]       CTI_O,
   input  logic [1:0]       BTE_O,
   output logic [31:0]      MDAT_I,
   output logic             ACK_I,
   output logic             RTY_I,
   output logic             ERR_I,
   input  logic [3:0]       cfg_wait,
   input  logic [3:0]       cfg_retry_every,
   output logic [CNT_W-1:0] ack_cnt,
   output logic [CNT_W-1:0] rty_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             burst_addr_err
);

   localparam int unsigned AW   = $clog2(MEM_WORDS);
   localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

   function automatic logic in_range(input logic [31:0] a);
      logic [32:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   resp_state_e      state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       wait_q, wait_d;
   logic [3:0]       retry_q, retry_d;
   logic [3:0]       cfg_wait_q, cfg_wait_d;
   logic [3:0]       cfg_retry_q, cfg_retry_d;
   logic             ack_q, ack_d, rty_q, rty_d, err_q, err_d;
   logic             in_cyc_q, in_cyc_d;
   logic             baerr_q, baerr_d;
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d, rty_cnt_q, rty_cnt_d, err_cnt_q, err_cnt_d;

   logic             req, resp_live, burst_beat, burst_ok;
   logic             ack_i, rty_i, err_i;
   logic [31:0]      dec_addr;
   logic [3:0]       cfg_retry_eff;
   logic [4:0]       retry_inc;
   logic             first_beat, retry_hit, dec_err, go_resp;
   logic [AW-1:0]    mem_idx;
   logic [31:0]      mem_rdata;

   // Classic terminations are registered; burst beats are qualified by the live strobe.
   assign req        = CYC_O & STB_O;
   assign resp_live  = (state_q == ST_RESP) & req;
   assign burst_beat = (state_q == ST_BURST) & req;
   assign burst_ok   = in_range(addr_q);
   assign ack_i      = (resp_live & ack_q) | (burst_beat & burst_ok);
   assign err_i      = (resp_live & err_q) | (burst_beat & ~burst_ok);
   assign rty_i      = resp_live & rty_q;
   assign mem_idx    = AW'((addr_q - BASE_ADDR) >> 2);

   pci_bridge_wb_bytemem #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (ack_i & WE_O),
      .addr  (mem_idx),
      .wdata (MDAT_O),
      .sel   (SEL_O),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wait_d      = wait_q;
      retry_d     = retry_q;
      cfg_wait_d  = cfg_wait_q;
      cfg_retry_d = cfg_retry_q;
      ack_d       = 1'b0;
      rty_d       = 1'b0;
      err_d       = 1'b0;
      baerr_d     = baerr_q;
      in_cyc_d    = CYC_O & (in_cyc_q | ack_i | rty_i | err_i);
      ack_cnt_d   = (ack_i && (ack_cnt_q != '1)) ? ack_cnt_q + 1'b1 : ack_cnt_q;
      rty_cnt_d   = (rty_i && (rty_cnt_q != '1)) ? rty_cnt_q + 1'b1 : rty_cnt_q;
      err_cnt_d   = (err_i && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

      dec_addr      = (state_q == ST_IDLE) ? ADR_O : addr_q;
      cfg_retry_eff = (state_q == ST_IDLE) ? cfg_retry_every : cfg_retry_q;
      first_beat    = ~in_cyc_q;
      retry_inc     = {1'b0, retry_q} + 5'd1;
      retry_hit     = first_beat && (cfg_retry_eff != 4'd0) && (retry_inc >= {1'b0, cfg_retry_eff});
      dec_err       = ~in_range(dec_addr);
      go_resp       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cfg_wait_d  = cfg_wait;
            cfg_retry_d = cfg_retry_every;
            if (req) begin
               addr_d = ADR_O;
               if (cfg_wait == 4'd0) begin
                  go_resp = 1'b1;
               end else begin
                  wait_d  = cfg_wait;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req)                 state_d = ST_IDLE;
            else if (wait_q <= 4'd1)  go_resp = 1'b1;
            else                      wait_d  = wait_q - 4'd1;
         end
         ST_RESP: begin
            if (ack_i && (CTI_O == CTI_INCR) && (cfg_wait_q == 4'd0)) begin
               state_d = ST_BURST;
               addr_d  = next_burst_addr(addr_q, BTE_O);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (req) begin
               if (ADR_O != addr_q) baerr_d = 1'b1;
               if (ack_i && (CTI_O == CTI_INCR)) addr_d  = next_burst_addr(addr_q, BTE_O);
               else                               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (go_resp) begin
         state_d = ST_RESP;
         err_d   = dec_err;
         rty_d   = ~dec_err & retry_hit;
         ack_d   = ~dec_err & ~retry_hit;
         if (first_beat && (cfg_retry_eff != 4'd0)) retry_d = retry_hit ? '0 : retry_inc[3:0];
      end

      if (!CYC_O) begin
         state_d = ST_IDLE;
         ack_d   = 1'b0;
         rty_d   = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wait_q      <= '0;
         retry_q     <= '0;
         cfg_wait_q  <= '0;
         cfg_retry_q <= '0;
         ack_q       <= 1'b0;
         rty_q       <= 1'b0;
         err_q       <= 1'b0;
         in_cyc_q    <= 1'b0;
         baerr_q     <= 1'b0;
         ack_cnt_q   <= '0;
         rty_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wait_q      <= wait_d;
         retry_q     <= retry_d;
         cfg_wait_q  <= cfg_wait_d;
         cfg_retry_q <= cfg_retry_d;
         ack_q       <= ack_d;
         rty_q       <= rty_d;
         err_q       <= err_d;
         in_cyc_q    <= in_cyc_d;
         baerr_q     <= baerr_d;
         ack_cnt_q   <= ack_cnt_d;
         rty_cnt_q   <= rty_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign ACK_I          = ack_i;
   assign RTY_I          = rty_i;
   assign ERR_I          = err_i;
   assign MDAT_I         = ack_i ? mem_rdata : '0;
   assign ack_cnt        = ack_cnt_q;
   assign rty_cnt        = rty_cnt_q;
   assign err_cnt        = err_cnt_q;
   assign burst_addr_err = baerr_q;

endmodule

// File: tb/tb_pci_bridge_wb_slave_responder.sv
// Directed bench for the WISHBONE slave responder: stimulus queues expected terminations,
// an independent negedge monitor pops and compares kind, cycle and read data.
module tb_pci_bridge_wb_slave_responder;

   localparam int unsigned MW = 256;
   localparam logic [2:0] K_ACK = 3'b001;
   localparam logic [2:0] K_RTY = 3'b010;
   localparam logic [2:0] K_ERR = 3'b100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ADR_O = '0, MDAT_O = '0;
   logic [3:0]  SEL_O = '0;
   logic        CYC_O = 1'b0, STB_O = 1'b0, WE_O = 1'b0;
   logic [2:0]  CTI_O = '0;
   logic [1:0]  BTE_O = '0;
   logic [3:0]  cfg_wait = '0, cfg_retry_every = '0;
   logic [31:0] MDAT_I;
   logic        ACK_I, RTY_I, ERR_I;
   logic [15:0] ack_cnt, rty_cnt, err_cnt;
   logic        burst_addr_err;

   pci_bridge_wb_slave_responder #(
      .MEM_WORDS (MW),
      .BASE_ADDR (32'h0000_0000),
      .CNT_W     (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ADR_O           (ADR_O),
      .MDAT_O          (MDAT_O),
      .SEL_O           (SEL_O),
      .CYC_O           (CYC_O),
      .STB_O           (STB_O),
      .WE_O            (WE_O),
      .CTI_O           (CTI_O),
      .BTE_O           (BTE_O),
      .MDAT_I          (MDAT_I),
      .ACK_I           (ACK_I),
      .RTY_I           (RTY_I),
      .ERR_I           (ERR_I),
      .cfg_wait        (cfg_wait),
      .cfg_retry_every (cfg_retry_every),
      .ack_cnt         (ack_cnt),
      .rty_cnt         (rty_cnt),
      .err_cnt         (err_cnt),
      .burst_addr_err  (burst_addr_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int unsigned n_pass = 0, n_total = 0, n_pushed = 0;

   typedef struct {
      logic [2:0]  kind;
      logic        chk_data;
      logic [31:0] data;
      int unsigned cyc;
      int unsigned id;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void push(input logic [2:0] kind, input logic chk, input logic [31:0] data,
                                input int unsigned cyc);
      exp_t e;
      e.kind = kind; e.chk_data = chk; e.data = data; e.cyc = cyc; e.id = n_pushed;
      n_pushed++;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (ACK_I || RTY_I || ERR_I)) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_term: got %b expected none at cycle %0d", {ERR_I, RTY_I, ACK_I}, cyc_cnt);
         end else begin
            e = sb.pop_front();
            check($sformatf("term_kind#%0d", e.id), 32'({ERR_I, RTY_I, ACK_I}), 32'(e.kind));
            check($sformatf("term_cycle#%0d", e.id), cyc_cnt, e.cyc);
            if (e.chk_data) check($sformatf("rd_data#%0d", e.id), MDAT_I, e.data);
         end
      end
   end

   task automatic wait_term();
      bit ok;
      ok = 1'b0;
      for (int unsigned i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ACK_I || RTY_I || ERR_I) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_total++;
         $display("FAIL term_timeout: got no termination expected one within 40 cycles");
      end
   endtask

   task automatic wb_single(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] kind, input logic [31:0] rd_exp);
      @(posedge clk); #1;
      push(kind, !we && (kind == K_ACK), rd_exp, cyc_cnt + 1 + 32'(cfg_wait));
      ADR_O = adr; MDAT_O = dat; SEL_O = sel; WE_O = we;
      CTI_O = 3'b000; BTE_O = 2'b00; CYC_O = 1'b1; STB_O = 1'b1;
      wait_term();
      @(posedge clk); #1;
      CYC_O = 1'b0; STB_O = 1'b0; WE_O = 1'b0;
   endtask

   task automatic wb_burst(input logic we, input logic [31:0] adr[4], input logic [31:0] dat[4],
                           input logic [31:0] rd[4]);
      int unsigned base;
      @(posedge clk); #1;
      base = cyc_cnt;
      for (int unsigned i = 0; i < 4; i++) push(K_ACK, !we, rd[i], base + 1 + i);
      BTE_O = 2'b01; SEL_O = 4'hF; WE_O = we; CYC_O = 1'b1; STB_O = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         ADR_O  = adr[i];
         MDAT_O = dat[i];
         CTI_O  = (i == 3) ? 3'b111 : 3'b010;
         wait_term();
         @(posedge clk); #1;
      end
      CYC_O = 1'b0; STB_O = 1'b0; WE_O = 1'b0; CTI_O = 3'b000; BTE_O = 2'b00;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] ad[4], dd[4], zz[4];

      #1;
      check("rst_ack", 32'(ACK_I), 0);
      check("rst_rty", 32'(RTY_I), 0);
      check("rst_err", 32'(ERR_I), 0);
      check("rst_mdat", MDAT_I, 0);
      check("rst_ack_cnt", 32'(ack_cnt), 0);
      check("rst_rty_cnt", 32'(rty_cnt), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_baerr", 32'(burst_addr_err), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // zero-wait classic write then read back
      wb_single(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, K_ACK, '0);
      wb_single(1'b0, 32'h10, '0, 4'hF, K_ACK, 32'hDEAD_BEEF);
      check("ack_cnt_t1", 32'(ack_cnt), 2);

      // three wait states and byte-masked write
      cfg_wait = 4'd3;
      wb_single(1'b0, 32'h10, '0, 4'hF, K_ACK, 32'hDEAD_BEEF);
      wb_single(1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, K_ACK, '0);
      wb_single(1'b1, 32'h14, 32'hAAAA_5555, 4'h3, K_ACK, '0);
      wb_single(1'b0, 32'h14, '0, 4'hF, K_ACK, 32'hFFFF_5555);
      check("ack_cnt_t2", 32'(ack_cnt), 6);

      // every second CYC retried, retried writes must not land
      cfg_wait = 4'd0;
      cfg_retry_every = 4'd2;
      wb_single(1'b1, 32'h18, 32'h1111_1111, 4'hF, K_ACK, '0);
      wb_single(1'b1, 32'h18, 32'h2222_2222, 4'hF, K_RTY, '0);
      wb_single(1'b0, 32'h18, '0, 4'hF, K_ACK, 32'h1111_1111);
      wb_single(1'b1, 32'h18, 32'h3333_3333, 4'hF, K_RTY, '0);
      cfg_retry_every = 4'd0;
      wb_single(1'b0, 32'h18, '0, 4'hF, K_ACK, 32'h1111_1111);
      check("rty_cnt_t3", 32'(rty_cnt), 2);
      check("ack_cnt_t3", 32'(ack_cnt), 9);

      // wrap4 bursts from 0x0C
      ad = '{32'h0C, 32'h00, 32'h04, 32'h08};
      dd = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
      zz = '{32'h0, 32'h0, 32'h0, 32'h0};
      wb_burst(1'b1, ad, dd, zz);
      check("baerr_wr_burst", 32'(burst_addr_err), 0);
      wb_burst(1'b0, ad, zz, dd);
      check("baerr_rd_burst", 32'(burst_addr_err), 0);
      check("ack_cnt_burst", 32'(ack_cnt), 17);
      ad = '{32'h0C, 32'h00, 32'h10, 32'h08};
      wb_burst(1'b0, ad, zz, dd);
      check("baerr_bad_beat", 32'(burst_addr_err), 1);
      check("ack_cnt_burst2", 32'(ack_cnt), 21);

      // range boundary: first word past the end errors and must not alias onto word 0
      wb_single(1'b1, 32'(MW) * 4, 32'h5A5A_5A5A, 4'hF, K_ERR, '0);
      check("err_cnt_t5", 32'(err_cnt), 1);
      wb_single(1'b1, 32'(MW) * 4 - 4, 32'hC0FF_EE00, 4'hF, K_ACK, '0);
      wb_single(1'b0, 32'(MW) * 4 - 4, '0, 4'hF, K_ACK, 32'hC0FF_EE00);
      wb_single(1'b0, 32'h00, '0, 4'hF, K_ACK, 32'hB1B1_1111);
      check("ack_cnt_t5", 32'(ack_cnt), 24);

      // reset asserted while a write sits in WAIT
      wb_single(1'b1, 32'h20, 32'h1234_5678, 4'hF, K_ACK, '0);
      check("ack_cnt_pre_rst", 32'(ack_cnt), 25);
      cfg_wait = 4'd5;
      @(posedge clk); #1;
      ADR_O = 32'h20; MDAT_O = 32'hBAD0_BAD0; SEL_O = 4'hF; WE_O = 1'b1;
      CTI_O = 3'b000; CYC_O = 1'b1; STB_O = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ack", 32'(ACK_I), 0);
      check("mid_rst_rty", 32'(RTY_I), 0);
      check("mid_rst_err", 32'(ERR_I), 0);
      check("mid_rst_mdat", MDAT_I, 0);
      check("mid_rst_ack_cnt", 32'(ack_cnt), 0);
      check("mid_rst_err_cnt", 32'(err_cnt), 0);
      check("mid_rst_rty_cnt", 32'(rty_cnt), 0);
      check("mid_rst_baerr", 32'(burst_addr_err), 0);
      CYC_O = 1'b0; STB_O = 1'b0; WE_O = 1'b0;
      cfg_wait = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      wb_single(1'b0, 32'h20, '0, 4'hF, K_ACK, 32'h1234_5678);
      check("ack_cnt_post_rst", 32'(ack_cnt), 1);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
